// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: MMIO decode, FIFO push/pop sequencing, occupancy/flag tracking, drain FSM and read responses
module mmio_fifo_ctrl #(
    parameter int          DEPTH     = 8,
    parameter int          DATA_W    = 64,
    parameter int          TID_W     = 9,
    parameter logic [15:0] BASE_ADDR = 16'h0020,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [15:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    input  logic [15:0]       rd_addr,
    input  logic [TID_W-1:0]  rd_tid,
    output logic              rsp_valid,
    output logic [TID_W-1:0]  rsp_tid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              fifo_push,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              fifo_pop,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              draining
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              data_wr, ctrl_wr, data_rd, stat_rd, ctrl_rd, idle, ctrl_clr;

    assign full       = count_q == CW'(DEPTH);
    assign empty      = count_q == '0;
    assign count      = count_q;
    assign draining   = state_q == DRAIN;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_tid    = rsp_tid_q;
    assign rsp_data   = rsp_data_q;
    assign fifo_wdata = wr_data;

    // Decode requests, drive FIFO strobes, compute next occupancy, flags, FSM and response
    always_comb begin
        data_wr     = wr_valid && wr_addr == BASE_ADDR;
        ctrl_wr     = wr_valid && wr_addr == BASE_ADDR + 16'd4;
        data_rd     = rd_valid && rd_addr == BASE_ADDR;
        stat_rd     = rd_valid && rd_addr == BASE_ADDR + 16'd2;
        ctrl_rd     = rd_valid && rd_addr == BASE_ADDR + 16'd4;
        idle        = state_q == IDLE;
        ctrl_clr    = ctrl_wr && wr_data[1];
        fifo_pop    = !rst && (idle ? data_rd && !empty : !empty);
        fifo_push   = !rst && idle && data_wr && (!full || fifo_pop);
        count_d     = count_q + CW'(fifo_push) - CW'(fifo_pop);
        ovf_d       = !ctrl_clr && (ovf_q || data_wr && !fifo_push);
        udf_d       = !ctrl_clr && (udf_q || data_rd && (!idle || empty));
        state_d     = idle ? (ctrl_wr && wr_data[0] ? DRAIN : IDLE)
                           : (count_q <= CW'(1) ? IDLE : DRAIN);
        rsp_valid_d = data_rd || stat_rd || ctrl_rd;
        rsp_tid_d   = rd_tid;
        rsp_data_d  = data_rd ? (idle && !empty ? fifo_rdata : '0)
                    : stat_rd ? DATA_W'({full, empty, ovf_q, udf_q, 44'b0, 16'(count_q)})
                    : ctrl_rd ? DATA_W'({draining, 1'b0})
                    : '0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb_mmio_fifo_ctrl: directed and randomized checks of mmio_fifo_ctrl against a queue-based reference model
module tb_mmio_fifo_ctrl;
    localparam logic [15:0] D = 16'h0020, S = 16'h0022, C = 16'h0024, U = 16'h0030;

    logic        clk = 0, rst = 1;
    logic        wr_valid = 0, rd_valid = 0;
    logic [15:0] wr_addr = 0, rd_addr = 0;
    logic [63:0] wr_data = 0;
    logic [8:0]  rd_tid = 0;
    logic        rsp_valid, fifo_push, fifo_pop, full, empty, draining;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data, fifo_wdata, fifo_rdata;
    logic [3:0]  count;

    int checks = 0, failures = 0;

    // reference model state
    logic [63:0] mq[$];
    bit          m_ovf, m_udf, m_drain, e_push, e_pop, e_rv;
    logic [63:0] e_rd;
    logic [8:0]  e_tid;

    // emulated FIFO instance driven by the controller's strobes
    logic [63:0] ram [8];
    logic [2:0]  rp, wp;

    mmio_fifo_ctrl dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tid(rd_tid), .rsp_valid(rsp_valid),
        .rsp_tid(rsp_tid), .rsp_data(rsp_data), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
        .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .count(count), .full(full),
        .empty(empty), .draining(draining)
    );

    always #5 clk = ~clk;

    assign fifo_rdata = ram[rp];

    always @(posedge clk) begin
        if (rst) begin
            rp <= 0;
            wp <= 0;
        end else begin
            if (fifo_pop) rp <= rp + 3'd1;
            if (fifo_push) begin
                ram[wp] <= fifo_wdata;
                wp <= wp + 3'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        if (e_rv) begin
            chk("rsp_tid", 64'(rsp_tid), 64'(e_tid));
            chk("rsp_data", rsp_data, e_rd);
        end
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == 8));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("draining", 64'(draining), 64'(m_drain));
    endtask

    task automatic do_reset();
        rst = 1; wr_valid = 0; rd_valid = 0;
        @(negedge clk);
        chk("rst_push", 64'(fifo_push), 64'd0);
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        mq.delete();
        m_ovf = 0; m_udf = 0; m_drain = 0; e_rv = 0;
        check_regs();
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
    endtask

    // one cycle of MMIO traffic: predict, check strobes mid-cycle, check registered state after the edge
    task automatic step(input bit wv, input logic [15:0] wa, input logic [63:0] wd,
                        input bit rv, input logic [15:0] ra, input logic [8:0] tid);
        bit dw, dr, sr, cr, cw, nd, n_ovf, n_udf;
        int n;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rd_tid = tid;
        dw = wv && wa == D; cw = wv && wa == C;
        dr = rv && ra == D; sr = rv && ra == S; cr = rv && ra == C;
        n = mq.size();
        n_ovf = m_ovf; n_udf = m_udf;
        if (!m_drain) begin
            e_pop  = dr && n > 0;
            e_push = dw && (n < 8 || e_pop);
            if (dw && !e_push) n_ovf = 1;
            if (dr && n == 0) n_udf = 1;
            nd = cw && wd[0];
        end else begin
            e_pop  = n > 0;
            e_push = 0;
            if (dw) n_ovf = 1;
            if (dr) n_udf = 1;
            nd = n > 1;
        end
        if (cw && wd[1]) begin n_ovf = 0; n_udf = 0; end
        e_rv  = dr || sr || cr;
        e_tid = tid;
        e_rd  = dr ? ((!m_drain && n > 0) ? mq[0] : 64'd0)
              : sr ? {n == 8, n == 0, m_ovf, m_udf, 44'b0, 16'(n)}
              : {62'b0, m_drain, 1'b0};
        @(negedge clk);
        chk("fifo_push", 64'(fifo_push), 64'(e_push));
        chk("fifo_pop", 64'(fifo_pop), 64'(e_pop));
        if (e_push) chk("fifo_wdata", fifo_wdata, wd);
        if (e_pop) void'(mq.pop_front());
        if (e_push) mq.push_back(wd);
        m_ovf = n_ovf; m_udf = n_udf; m_drain = nd;
        @(posedge clk); #1;
        wr_valid = 0; rd_valid = 0;
        check_regs();
    endtask

    task automatic idle_step();
        step(0, D, 0, 0, D, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // 1: STATUS after reset
        step(0, D, 0, 1, S, 9'h1A5);
        chk("t1_status", rsp_data, 64'h4000_0000_0000_0000);
        chk("t1_tid", 64'(rsp_tid), 64'h1A5);
        // 2: fill, then overflow
        for (int i = 1; i <= 8; i++) step(1, D, 64'(i), 0, D, 0);
        step(1, D, 64'hDEAD, 0, D, 0);
        step(0, D, 0, 1, S, 9'h002);
        chk("t2_ovf_bit", 64'(rsp_data[61]), 64'd1);
        chk("t2_count", 64'(count), 64'd8);
        // 3: drain by reads, then underflow
        for (int i = 1; i <= 8; i++) begin
            step(0, D, 0, 1, D, 9'(i));
            chk("t3_data", rsp_data, 64'(i));
        end
        step(0, D, 0, 1, D, 9'h0FF);
        chk("t3_underflow", rsp_data, 64'd0);
        // CTRL clear, unmapped read, back-to-back STATUS/CTRL reads
        step(1, C, 64'h2, 1, U, 9'h010);
        step(0, D, 0, 1, S, 9'h011);
        step(0, D, 0, 1, C, 9'h012);
        // 4: simultaneous read and write when full
        for (int i = 0; i < 8; i++) step(1, D, 64'h100 + 64'(i), 0, D, 0);
        step(1, D, 64'h55, 1, D, 9'h020);
        chk("t4_head", rsp_data, 64'h100);
        for (int i = 0; i < 8; i++) step(0, D, 0, 1, D, 9'(i));
        chk("t4_tail", rsp_data, 64'h55);
        // simultaneous read and write when empty
        step(1, D, 64'h77, 1, D, 9'h021);
        step(0, D, 0, 1, D, 9'h022);
        // 5: drain with a dropped write and a read during drain
        for (int i = 0; i < 5; i++) step(1, D, 64'h200 + 64'(i), 0, D, 0);
        step(1, C, 64'h1, 0, D, 0);
        step(1, D, 64'hBAD, 1, D, 9'h030);
        step(0, D, 0, 1, C, 9'h031);
        repeat (4) idle_step();
        chk("t5_idle", 64'(draining), 64'd0);
        step(1, C, 64'h1, 0, D, 0);
        idle_step();
        // 6: clear flags, then reset mid-drain
        step(1, C, 64'h2, 1, S, 9'h040);
        step(0, D, 0, 1, S, 9'h041);
        for (int i = 0; i < 6; i++) step(1, D, 64'h300 + 64'(i), 0, D, 0);
        step(1, C, 64'h1, 0, D, 0);
        idle_step();
        do_reset();
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [15:0] wa, ra;
            logic [63:0] wd;
            int r;
            r  = $urandom_range(0, 99);
            wa = r < 60 ? D : r < 70 ? S : r < 85 ? C : U;
            r  = $urandom_range(0, 99);
            ra = r < 55 ? D : r < 70 ? S : r < 85 ? C : U;
            wd = {$urandom, $urandom};
            if (wa == C) wd[0] = $urandom_range(0, 9) == 0;
            if (wa == C) wd[1] = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 149) == 0) do_reset();
            else step($urandom_range(0, 99) < 55, wa, wd, $urandom_range(0, 99) < 45, ra, 9'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
